// File: rtl/search_scan_ctrl.sv
// search_scan_ctrl: raster scan of every template-sized window of an image, tracking the lowest-scoring window.
//   clk, rst              : clock and synchronous active-high reset
//   start                 : scan request, taken only when idle
//   busy, done            : scan in progress / one-cycle completion pulse
//   pix_valid, pix_ready  : request handshake for one (image, template) pixel pair
//   img_row/col, tpl_row/col, pix_last : requested coordinates, last pixel of the window
//   score_valid, score    : window score returned by the compare datapath
//   best_row/col, best_score : origin and score of the best window so far
module search_scan_ctrl #(
    parameter int IMG_ROWS    = 9,
    parameter int IMG_COLS    = 8,
    parameter int TPL_ROWS    = 3,
    parameter int TPL_COLS    = 3,
    parameter int COUNT_WIDTH = 4,
    parameter int SCORE_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [COUNT_WIDTH-1:0] img_row,
    output logic [COUNT_WIDTH-1:0] img_col,
    output logic [COUNT_WIDTH-1:0] tpl_row,
    output logic [COUNT_WIDTH-1:0] tpl_col,
    output logic                   pix_last,
    input  logic                   score_valid,
    input  logic [SCORE_W-1:0]     score,
    output logic [COUNT_WIDTH-1:0] best_row,
    output logic [COUNT_WIDTH-1:0] best_col,
    output logic [SCORE_W-1:0]     best_score
);
    localparam logic [COUNT_WIDTH-1:0] TR_MAX = COUNT_WIDTH'(TPL_ROWS - 1);
    localparam logic [COUNT_WIDTH-1:0] TC_MAX = COUNT_WIDTH'(TPL_COLS - 1);
    localparam logic [COUNT_WIDTH-1:0] WY_MAX = COUNT_WIDTH'(IMG_ROWS - TPL_ROWS);
    localparam logic [COUNT_WIDTH-1:0] WX_MAX = COUNT_WIDTH'(IMG_COLS - TPL_COLS);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] wy_q, wy_d, wx_q, wx_d, tr_q, tr_d, tc_q, tc_d;
    logic [COUNT_WIDTH-1:0] best_row_q, best_row_d, best_col_q, best_col_d;
    logic [SCORE_W-1:0]     best_score_q, best_score_d;

    assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign done       = state_q == S_DONE;
    assign pix_valid  = state_q == S_ISSUE;
    assign pix_last   = pix_valid && tr_q == TR_MAX && tc_q == TC_MAX;
    assign img_row    = wy_q + tr_q;
    assign img_col    = wx_q + tc_q;
    assign tpl_row    = tr_q;
    assign tpl_col    = tc_q;
    assign best_row   = best_row_q;
    assign best_col   = best_col_q;
    assign best_score = best_score_q;

    always_comb begin
        state_d      = state_q;
        wy_d         = wy_q;
        wx_d         = wx_q;
        tr_d         = tr_q;
        tc_d         = tc_q;
        best_row_d   = best_row_q;
        best_col_d   = best_col_q;
        best_score_d = best_score_q;
        unique case (state_q)
            S_IDLE: if (start) begin
                state_d      = S_ISSUE;
                wy_d         = '0;
                wx_d         = '0;
                tr_d         = '0;
                tc_d         = '0;
                best_row_d   = '0;
                best_col_d   = '0;
                best_score_d = '1;
            end
            S_ISSUE: if (pix_ready) begin
                state_d = pix_last ? S_WAIT : S_ISSUE;
                tc_d    = (tc_q == TC_MAX) ? '0 : tc_q + 1'b1;
                tr_d    = pix_last ? '0 : (tc_q == TC_MAX) ? tr_q + 1'b1 : tr_q;
            end
            S_WAIT: if (score_valid) begin
                if (score < best_score_q) begin
                    best_score_d = score;
                    best_row_d   = wy_q;
                    best_col_d   = wx_q;
                end
                // Final window: park the origin at zero rather than stepping past the image.
                if (wy_q == WY_MAX && wx_q == WX_MAX) begin
                    state_d = S_DONE;
                    wy_d    = '0;
                    wx_d    = '0;
                end else begin
                    state_d = S_ISSUE;
                    wx_d    = (wx_q == WX_MAX) ? '0 : wx_q + 1'b1;
                    wy_d    = (wx_q == WX_MAX) ? wy_q + 1'b1 : wy_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wy_q         <= '0;
            wx_q         <= '0;
            tr_q         <= '0;
            tc_q         <= '0;
            best_row_q   <= '0;
            best_col_q   <= '0;
            best_score_q <= '1;
        end else begin
            state_q      <= state_d;
            wy_q         <= wy_d;
            wx_q         <= wx_d;
            tr_q         <= tr_d;
            tc_q         <= tc_d;
            best_row_q   <= best_row_d;
            best_col_q   <= best_col_d;
            best_score_q <= best_score_d;
        end
    end
endmodule

// File: tb/tb_search_scan_ctrl.sv
// tb_search_scan_ctrl: randomized scan runs checked against a window-enumeration reference model.
module tb_search_scan_ctrl;
    localparam int IR = 9, IC = 8, TR = 3, TC = 3, CW = 4, SW = 16;
    localparam int NY = IR - TR + 1, NX = IC - TC + 1, NW = NY * NX, NP = TR * TC;

    logic          clk = 1'b0, rst, start, pix_ready, score_valid;
    logic [SW-1:0] score;
    logic          busy, done, pix_valid, pix_last;
    logic [CW-1:0] img_row, img_col, tpl_row, tpl_col, best_row, best_col;
    logic [SW-1:0] best_score;

    int checks = 0, errors = 0;

    search_scan_ctrl #(
        .IMG_ROWS(IR), .IMG_COLS(IC), .TPL_ROWS(TR), .TPL_COLS(TC),
        .COUNT_WIDTH(CW), .SCORE_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .img_row(img_row), .img_col(img_col), .tpl_row(tpl_row), .tpl_col(tpl_col),
        .pix_last(pix_last), .score_valid(score_valid), .score(score),
        .best_row(best_row), .best_col(best_col), .best_score(best_score)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_valid"}, 32'(pix_valid), 0);
        check({tag, "_last"}, 32'(pix_last), 0);
        check({tag, "_coords"}, {16'd0, img_row, img_col, tpl_row, tpl_col}, 0);
        check({tag, "_best_score"}, 32'(best_score), 32'hFFFF);
    endtask

    // mode 0: constant 100; 1: 10 at (4,2) else 50; 2: random; 3: 5 at (1,1) and (3,0) else 20
    task automatic run_scan(input int mode, input bit stall, input bit noise, input int abort_at);
        int sc[NW];
        int bs, bw, xfer, lasts, wins, dones, w, p;
        bit fin, stalled;
        logic [16:0] cur, prev, exp;
        for (int i = 0; i < NW; i++) begin
            sc[i] = mode == 0 ? 100 :
                    mode == 1 ? (i == 4 * NX + 2 ? 10 : 50) :
                    mode == 3 ? ((i == 1 * NX + 1 || i == 3 * NX + 0) ? 5 : 20) :
                    int'($urandom_range(0, 400));
        end
        bs = 65535;
        bw = 0;
        for (int i = 0; i < NW; i++) if (sc[i] < bs) begin bs = sc[i]; bw = i; end
        xfer = 0; lasts = 0; wins = 0; dones = 0; fin = 0; stalled = 0; prev = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
            pix_ready = 1'b0; score_valid = 1'b0; score = '0; start = 1'b0;
            if (done) begin
                dones++;
                fin = 1;
                check("done_not_busy", 32'(busy), 0);
            end else if (pix_valid) begin
                w = xfer / NP;
                p = xfer % NP;
                exp = {p == NP - 1, CW'(w / NX + p / TC), CW'(w % NX + p % TC), CW'(p / TC), CW'(p % TC)};
                cur = {pix_last, img_row, img_col, tpl_row, tpl_col};
                if (stalled) check("stall_hold", 32'(cur), 32'(prev));
                check("xfer_coord", 32'(cur), 32'(exp));
                if (xfer == abort_at) begin
                    rst = 1'b1; pix_ready = 1'b1; score_valid = 1'b1; start = 1'b1;
                    @(negedge clk);
                    rst = 1'b0; pix_ready = 1'b0; score_valid = 1'b0; start = 1'b0;
                    check_idle_outputs("abort");
                    for (int k = 0; k < 10; k++) begin
                        @(negedge clk);
                        if (done || busy) check("abort_quiet", {30'd0, done, busy}, 0);
                    end
                    return;
                end
                pix_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                stalled = !pix_ready;
                prev = cur;
                if (pix_ready) begin
                    xfer++;
                    if (pix_last) lasts++;
                end
                if (noise) begin
                    score_valid = 1'($urandom_range(0, 1));
                    start = 1'($urandom_range(0, 1));
                end
            end else if (busy) begin
                stalled = 0;
                if ($urandom_range(0, 3) == 0 && wins < NW) begin
                    score_valid = 1'b1;
                    score = SW'(sc[wins]);
                    wins++;
                end
            end
            @(negedge clk);
        end
        pix_ready = 1'b0; score_valid = 1'b0; start = 1'b0;
        check("done_seen", 32'(fin), 1);
        for (int k = 0; k < 4; k++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("transfers", xfer, NW * NP);
        check("last_pulses", lasts, NW);
        check("scores_taken", wins, NW);
        check("done_pulses", dones, 1);
        check("idle_busy", 32'(busy), 0);
        check("best_row", 32'(best_row), bw / NX);
        check("best_col", 32'(best_col), bw % NX);
        check("best_score", 32'(best_score), bs);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pix_ready = 1'b0; score_valid = 1'b0; score = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("reset");
        run_scan(0, 0, 0, -1);
        run_scan(1, 0, 0, -1);
        run_scan(0, 1, 0, -1);
        run_scan(2, 1, 0, -1);
        run_scan(0, 0, 1, -1);
        run_scan(1, 0, 0, 100);
        run_scan(0, 0, 0, -1);
        run_scan(3, 0, 0, -1);
        run_scan(3, 1, 1, -1);
        run_scan(2, 1, 1, -1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
